// File: rtl/eth_pkg.sv
// Shared types for the Ethernet TX frame FIFO.
// Beat layout and the two FSM state encodings.
package eth_pkg;

  localparam int AXIS_DATA_W = 32;

  typedef enum logic {
    WR_ACCEPT,
    WR_DROP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_SEND
  } rd_state_t;

  typedef struct packed {
    logic                   tlast;
    logic [AXIS_DATA_W-1:0] tdata;
  } fifo_entry_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read data holds its value while re_i is low.
module sdp_ram #(
  parameter  int DEPTH  = 256,
  parameter  int WIDTH  = 33,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/eth_tx_frame_fifo.sv
// Store-and-forward TX frame FIFO: a frame is released only once
// its last beat is stored; frames larger than the buffer are dropped.
module eth_tx_frame_fifo
  import eth_pkg::*;
#(
  parameter  int DEPTH  = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [AXIS_DATA_W-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  output logic [AXIS_DATA_W-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic                   frame_drop,
  output logic [ADDR_W:0]        frames_stored
);

  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] PTR_FULL = (ADDR_W+1)'(DEPTH);

  wr_state_t   wr_state_q, wr_state_d;
  rd_state_t   rd_state_q, rd_state_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] wr_commit_q, wr_commit_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W:0] frames_q, frames_d;
  logic [ADDR_W:0] used;
  logic        ram_vld_q, ram_vld_d;
  logic        out_vld_q, out_vld_d;
  fifo_entry_t out_q, out_d;
  fifo_entry_t ram_rdata, wr_entry;
  logic        drop_q, drop_d;
  logic        full, s_rdy, we, commit;
  logic        out_hs, last_hs, load_out, fetch;

  assign used     = wr_ptr_q - rd_ptr_q;
  assign full     = (used == PTR_FULL);
  assign wr_entry = '{tlast: s_axis_tlast, tdata: s_axis_tdata};

  always_comb begin
    wr_state_d  = wr_state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    s_rdy       = 1'b0;
    we          = 1'b0;
    commit      = 1'b0;
    drop_d      = 1'b0;
    unique case (wr_state_q)
      WR_ACCEPT: begin
        s_rdy = !full;
        if (full && (wr_commit_q == rd_ptr_q)) begin
          // partial frame alone fills the buffer: rewind and sink it
          wr_ptr_d   = wr_commit_q;
          wr_state_d = WR_DROP;
        end else if (s_axis_tvalid && !full) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          if (s_axis_tlast) begin
            wr_commit_d = wr_ptr_q + PTR_ONE;
            commit      = 1'b1;
          end
        end
      end
      WR_DROP: begin
        s_rdy = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          drop_d     = 1'b1;
          wr_state_d = WR_ACCEPT;
        end
      end
      default: wr_state_d = WR_ACCEPT;
    endcase
  end

  // RAM read stage feeds the output register; space frees on handshake
  always_comb begin
    out_hs    = out_vld_q && m_axis_tready;
    last_hs   = out_hs && out_q.tlast;
    load_out  = ram_vld_q && (!out_vld_q || m_axis_tready);
    fetch     = (rd_addr_q != wr_commit_q) && (!ram_vld_q || load_out);
    ram_vld_d = fetch || (ram_vld_q && !load_out);
    out_vld_d = load_out || (out_vld_q && !m_axis_tready);
    out_d     = load_out ? ram_rdata : out_q;
    rd_addr_d = fetch ? rd_addr_q + PTR_ONE : rd_addr_q;
    rd_ptr_d  = out_hs ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    frames_d  = frames_q;
    if (commit && !last_hs) begin
      frames_d = frames_q + PTR_ONE;
    end else if (!commit && last_hs) begin
      frames_d = frames_q - PTR_ONE;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      RD_IDLE: if (frames_q != '0) rd_state_d = RD_SEND;
      RD_SEND: if (last_hs && frames_d == '0) rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state_q  <= WR_ACCEPT;
      rd_state_q  <= RD_IDLE;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      rd_addr_q   <= '0;
      frames_q    <= '0;
      ram_vld_q   <= 1'b0;
      out_vld_q   <= 1'b0;
      out_q       <= '0;
      drop_q      <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      rd_state_q  <= rd_state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_addr_q   <= rd_addr_d;
      frames_q    <= frames_d;
      ram_vld_q   <= ram_vld_d;
      out_vld_q   <= out_vld_d;
      out_q       <= out_d;
      drop_q      <= drop_d;
    end
  end

  sdp_ram #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_ram (
    .clk_i   (aclk),
    .we_i    (we && !areset),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (wr_entry),
    .re_i    (fetch),
    .raddr_i (rd_addr_q[ADDR_W-1:0]),
    .rdata_o (ram_rdata)
  );

  assign s_axis_tready = s_rdy && !areset;
  assign m_axis_tdata  = out_q.tdata;
  assign m_axis_tlast  = out_q.tlast;
  assign m_axis_tvalid = out_vld_q;
  assign frame_drop    = drop_q;
  assign frames_stored = frames_q;

endmodule

// File: tb/tb_eth_tx_frame_fifo.sv
// Scoreboard bench for eth_tx_frame_fifo with an 8-entry buffer.
// Input beats are queued per frame and matched against output beats.
module tb_eth_tx_frame_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int TMO   = 2000;

  logic          aclk = 0;
  logic          areset = 1;
  logic [31:0]   s_tdata = '0;
  logic          s_tvalid = 0;
  logic          s_tlast = 0;
  logic          s_tready;
  logic [31:0]   m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 0;
  logic          frame_drop;
  logic [AW:0]   frames_stored;

  eth_tx_frame_fifo #(.DEPTH(DEPTH)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .frame_drop    (frame_drop),
    .frames_stored (frames_stored)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  logic [32:0] sb[$];
  logic [32:0] pend[$];
  bit   drop_exp = 0;
  int   cyc = 0;
  int   in_cnt = 0, out_cnt = 0, drop_cnt = 0, starts = 0;
  int   in_last_cyc = 0, rise_cyc = 0, last_out_cyc = -10;
  logic prev_tv = 0, prev_stall = 0, prev_rst = 1, prev_last = 0;
  logic [31:0] prev_data = '0;

  always @(posedge aclk) cyc++;

  always @(negedge aclk) begin
    logic [32:0] e;
    if (areset) begin
      sb.delete();
      pend.delete();
    end else begin
      if (s_tvalid && s_tready) begin
        in_cnt++;
        pend.push_back({s_tlast, s_tdata});
        if (s_tlast) begin
          in_last_cyc = cyc;
          if (!drop_exp) foreach (pend[i]) sb.push_back(pend[i]);
          pend.delete();
        end
      end
      if (m_tvalid && m_tready) begin
        out_cnt++;
        if (last_out_cyc != cyc - 1) starts++;
        last_out_cyc = cyc;
        if (sb.size() == 0) begin
          chk("unexpected_out", {m_tlast, m_tdata}, 33'h0);
        end else begin
          e = sb.pop_front();
          chk("out_data", m_tdata, e[31:0]);
          chk("out_last", m_tlast, e[32]);
        end
      end
      if (prev_stall && !prev_rst) begin
        chk("stall_valid", m_tvalid, 1);
        chk("stall_data", m_tdata, prev_data);
        chk("stall_last", m_tlast, prev_last);
      end
      if (m_tvalid && !prev_tv) rise_cyc = cyc;
      if (frame_drop) drop_cnt++;
    end
    prev_tv    = m_tvalid;
    prev_stall = m_tvalid && !m_tready;
    prev_data  = m_tdata;
    prev_last  = m_tlast;
    prev_rst   = areset;
  end

  task automatic send_frame(input int n, input logic [31:0] base,
                            input bit dropx);
    bit acc;
    int t;
    drop_exp = dropx;
    for (int i = 0; i < n; i++) begin
      s_tdata  = base + 32'(i) * 32'h11;
      s_tlast  = (i == n - 1);
      s_tvalid = 1;
      t = 0;
      acc = 0;
      while (!acc && t < TMO) begin
        @(negedge aclk);
        acc = s_tready;
        @(posedge aclk);
        #1;
        t++;
      end
      if (!acc) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    s_tvalid = 0;
    s_tlast  = 0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || m_tvalid) && t < TMO) begin
      @(posedge aclk);
      #1;
      t++;
    end
    if (t >= TMO) chk("drain_timeout", 0, 1);
  endtask

  bit rand_en = 0;
  bit f2_done = 0;

  initial begin
    int out0, st0, d0, in0, tot, t;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_drop", frame_drop, 0);
    chk("rst_frames", frames_stored, 0);
    @(posedge aclk);
    #1;
    areset = 0;
    @(negedge aclk);
    chk("post_rst_tready", s_tready, 1);
    @(posedge aclk);
    #1;

    // single 4-beat frame, latency and back-to-back output
    m_tready = 1;
    out0 = out_cnt;
    st0  = starts;
    send_frame(4, 32'h11, 0);
    @(negedge aclk);
    chk("t1_frames_1", frames_stored, 1);
    @(posedge aclk);
    #1;
    drain();
    chk("t1_latency", rise_cyc - in_last_cyc, 3);
    chk("t1_out_cnt", out_cnt - out0, 4);
    chk("t1_no_bubble", starts - st0, 1);
    chk("t1_frames_0", frames_stored, 0);

    // three frames held back, then released
    m_tready = 0;
    send_frame(1, 32'h100, 0);
    send_frame(2, 32'h200, 0);
    send_frame(5, 32'h300, 0);
    repeat (4) @(posedge aclk);
    #1;
    @(negedge aclk);
    chk("t2_frames_3", frames_stored, 3);
    chk("t2_hold_valid", m_tvalid, 1);
    chk("t2_hold_data", m_tdata, 32'h100);
    @(posedge aclk);
    #1;
    out0 = out_cnt;
    st0  = starts;
    m_tready = 1;
    drain();
    chk("t2_out_cnt", out_cnt - out0, 8);
    chk("t2_no_bubble", starts - st0, 1);
    chk("t2_frames_0", frames_stored, 0);

    // oversize frame is dropped, next frame intact
    d0   = drop_cnt;
    out0 = out_cnt;
    send_frame(12, 32'h1000, 1);
    repeat (5) @(posedge aclk);
    #1;
    chk("t3_drop_once", drop_cnt - d0, 1);
    chk("t3_no_output", out_cnt - out0, 0);
    chk("t3_frames_0", frames_stored, 0);
    send_frame(2, 32'h2000, 0);
    drain();
    chk("t3_next_out", out_cnt - out0, 2);
    chk("t3_drop_still", drop_cnt - d0, 1);

    // backpressure with committed frame, data straddles the wrap
    m_tready = 0;
    d0   = drop_cnt;
    out0 = out_cnt;
    send_frame(6, 32'h3000, 0);
    in0 = in_cnt;
    fork
      begin
        send_frame(4, 32'h4000, 0);
        f2_done = 1;
      end
    join_none
    repeat (10) @(posedge aclk);
    #1;
    @(negedge aclk);
    chk("t4_accepted_2", in_cnt - in0, 2);
    chk("t4_tready_low", s_tready, 0);
    chk("t4_frames_1", frames_stored, 1);
    @(posedge aclk);
    #1;
    m_tready = 1;
    t = 0;
    while (!f2_done && t < TMO) begin
      @(posedge aclk);
      #1;
      t++;
    end
    if (!f2_done) chk("t4_f2_timeout", 0, 1);
    drain();
    chk("t4_out_cnt", out_cnt - out0, 10);
    chk("t4_no_drop", drop_cnt - d0, 0);
    chk("t4_frames_0", frames_stored, 0);

    // random downstream stalls over 20 frames
    out0 = out_cnt;
    tot  = 0;
    rand_en = 1;
    fork
      while (rand_en) begin
        @(posedge aclk);
        #1;
        m_tready = 1'($urandom_range(0, 1));
      end
    join_none
    for (int f = 0; f < 20; f++) begin
      int len;
      len = $urandom_range(1, 7);
      tot += len;
      send_frame(len, 32'h5000_0000 + (32'(f) << 8), 0);
    end
    rand_en = 0;
    @(posedge aclk);
    #2;
    m_tready = 1;
    drain();
    chk("t5_out_cnt", out_cnt - out0, tot);
    chk("t5_frames_0", frames_stored, 0);

    // reset mid-frame with one frame stored
    @(posedge aclk);
    #1;
    m_tready = 0;
    send_frame(3, 32'h6000, 0);
    s_tvalid = 1;
    s_tlast  = 0;
    s_tdata  = 32'h7000;
    @(posedge aclk);
    #1;
    s_tdata = 32'h7011;
    @(posedge aclk);
    #1;
    areset   = 1;
    s_tvalid = 0;
    @(negedge aclk);
    chk("t6_rst_tready", s_tready, 0);
    @(posedge aclk);
    #1;
    areset = 0;
    @(negedge aclk);
    chk("t6_m_tvalid", m_tvalid, 0);
    chk("t6_m_tlast", m_tlast, 0);
    chk("t6_m_tdata", m_tdata, 0);
    chk("t6_frames", frames_stored, 0);
    chk("t6_drop", frame_drop, 0);
    chk("t6_tready_back", s_tready, 1);
    @(posedge aclk);
    #1;
    out0 = out_cnt;
    send_frame(3, 32'h8000, 0);
    @(negedge aclk);
    chk("t6_frames_1", frames_stored, 1);
    @(posedge aclk);
    #1;
    m_tready = 1;
    drain();
    chk("t6_out_cnt", out_cnt - out0, 3);
    chk("t6_frames_0", frames_stored, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
